// File: rtl/vga_screen_sequencer.sv
// VGA raster timing generator plus frame-synchronous screen selector.
// H/V counters advance once per pixel tick. Sync and blanking are decoded from
// the next-state counters, so they change on the same edge as H/V. Game-event
// requests are held in sticky pending bits and acted on only at the frame wrap.
module vga_screen_sequencer #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned H_TOTAL       = 800,
  parameter int unsigned V_TOTAL       = 525,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned H_ACT_START   = 144,
  parameter int unsigned H_ACT_END     = 783,
  parameter int unsigned V_ACT_START   = 35,
  parameter int unsigned V_ACT_END     = 514,
  parameter int unsigned SPLASH_FRAMES = 120,
  parameter int unsigned FLASH_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_req,
  input  logic        hit_req,
  input  logic        game_over_req,
  output logic [15:0] H_Counter_Value,
  output logic [15:0] V_Counter_Value,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic [1:0]  screen_sel
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast    = DivW'(CLK_DIV - 1);
  localparam logic [15:0]     HLast      = 16'(H_TOTAL - 1);
  localparam logic [15:0]     VLast      = 16'(V_TOTAL - 1);
  localparam logic [15:0]     HSyncW     = 16'(H_SYNC);
  localparam logic [15:0]     VSyncW     = 16'(V_SYNC);
  localparam logic [15:0]     HActS      = 16'(H_ACT_START);
  localparam logic [15:0]     HActE      = 16'(H_ACT_END);
  localparam logic [15:0]     VActS      = 16'(V_ACT_START);
  localparam logic [15:0]     VActE      = 16'(V_ACT_END);
  localparam logic [7:0]      SplashLast = 8'(SPLASH_FRAMES - 1);
  localparam logic [7:0]      FlashLast  = 8'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    StSplash = 2'd0,
    StBoard  = 2'd1,
    StFlash  = 2'd2,
    StOver   = 2'd3
  } screen_e;

  logic [DivW-1:0] div_q, div_d;
  logic [15:0]     h_q, h_d, v_q, v_d;
  logic            hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
  logic            frame_start_q;
  logic            tick, h_wrap, v_wrap, boundary;

  screen_e         state_q, state_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic            start_p_q, start_p_d, hit_p_q, hit_p_d, over_p_q, over_p_d;
  logic            eval_start, eval_hit, eval_over, flash_restart;

  // Pixel divider, raster counters and decode of the values they move to.
  always_comb begin
    tick   = (div_q == DivLast);
    div_d  = tick ? '0 : div_q + 1'b1;
    h_wrap = (h_q == HLast);
    v_wrap = (v_q == VLast);
    h_d    = h_q;
    v_d    = v_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = 16'd0;
        v_d = v_wrap ? 16'd0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
    boundary   = tick & h_wrap & v_wrap;
    hsync_d    = (h_d >= HSyncW);
    vsync_d    = (v_d >= VSyncW);
    video_on_d = (h_d >= HActS) && (h_d <= HActE) && (v_d >= VActS) && (v_d <= VActE);
  end

  // Pending requests and screen FSM; everything resolves at the frame wrap only.
  always_comb begin
    eval_start    = start_p_q | start_req;
    eval_hit      = hit_p_q | hit_req;
    eval_over     = over_p_q | game_over_req;
    start_p_d     = boundary ? 1'b0 : eval_start;
    hit_p_d       = boundary ? 1'b0 : eval_hit;
    over_p_d      = boundary ? 1'b0 : eval_over;
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    flash_restart = 1'b0;
    frame_cnt_inc = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;
    if (boundary) begin
      unique case (state_q)
        StSplash: if (eval_start && (frame_cnt_q >= SplashLast)) state_d = StBoard;
        StBoard: begin
          if (eval_over)     state_d = StOver;
          else if (eval_hit) state_d = StFlash;
        end
        StFlash: begin
          if (eval_over)                       state_d = StOver;
          else if (eval_hit)                   flash_restart = 1'b1;
          else if (frame_cnt_q == FlashLast)   state_d = StBoard;
        end
        StOver: if (eval_start) state_d = StSplash;
      endcase
      frame_cnt_d = ((state_d != state_q) || flash_restart) ? 8'd0 : frame_cnt_inc;
    end
  end

  // Timing registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      h_q           <= 16'd0;
      v_q           <= 16'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= boundary;
    end
  end

  // Screen state, frame counter and pending request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StSplash;
      frame_cnt_q <= 8'd0;
      start_p_q   <= 1'b0;
      hit_p_q     <= 1'b0;
      over_p_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      start_p_q   <= start_p_d;
      hit_p_q     <= hit_p_d;
      over_p_q    <= over_p_d;
    end
  end

  assign H_Counter_Value = h_q;
  assign V_Counter_Value = v_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign video_on        = video_on_q;
  assign frame_start     = frame_start_q;
  assign screen_sel      = state_q;

endmodule

// File: doc/vga_screen_sequencer.md
Name: vga_screen_sequencer

Overview:
- Owns VGA 640x480@60 raster timing and decides which screen renderer drives the RGB mux each frame.
- Screens: default red splash, game board, hit flash, game over.
- Generates the H/V counter values consumed by all screen renderers, plus sync and blanking signals.
- Latches game-event requests and applies screen changes only on frame boundaries, so no frame is torn.

Parameters:
- CLK_DIV, 4, system clocks per pixel tick (100 MHz -> 25 MHz).
- H_TOTAL, 800, pixel ticks per line.
- V_TOTAL, 525, lines per frame.
- H_SYNC, 96, hsync low width in ticks (H 0..95).
- V_SYNC, 2, vsync low width in lines (V 0..1).
- SPLASH_FRAMES, 120, minimum frames the splash is shown after reset or restart.
- FLASH_FRAMES, 30, frames the hit-flash screen is held.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- start_req, input, 1, one-cycle pulse: start or restart game.
- hit_req, input, 1, one-cycle pulse: shot hit, request flash.
- game_over_req, input, 1, one-cycle pulse: game ended.
- H_Counter_Value, output, 16, horizontal position 0..H_TOTAL-1.
- V_Counter_Value, output, 16, vertical position 0..V_TOTAL-1.
- hsync, output, 1, active-low horizontal sync.
- vsync, output, 1, active-low vertical sync.
- video_on, output, 1, high in visible window: H 144..783 and V 35..514.
- frame_start, output, 1, one-clk pulse at the frame wrap.
- screen_sel, output, 2, 0=splash, 1=board, 2=flash, 3=game over.

Behaviour:
- Reset (async, immediate): divider=0, H=0, V=0, hsync=0, vsync=0, video_on=0, frame_start=0, screen_sel=0, state=SPLASH, frame_cnt=0, all pending bits=0.
- Divider counts 0..CLK_DIV-1. tick is high in the cycle where divider==CLK_DIV-1.
- On tick, H increments. At H==H_TOTAL-1, H wraps to 0 and V increments. At V==V_TOTAL-1 it wraps to 0.
- Counters change only on tick edges.
- hsync, vsync and video_on are registered and decoded from the next-state counter values, so they align with H/V on the same edge.
- frame_start is high for exactly one clk: the cycle after the edge where H and V both wrap to 0.
- Pending bits start_p, hit_p and over_p are sticky. Each is set by its request pulse and evaluated only at a boundary (tick with H==H_TOTAL-1 and V==V_TOTAL-1).
- A request arriving on the boundary cycle counts for that boundary (eval = pending OR request).
- All pending bits are cleared at every boundary after evaluation. Requests irrelevant to the current state are discarded.
- frame_cnt increments at each boundary, saturating at 255. It is cleared on every state change.
- State transitions at a boundary, with priority game_over > hit > start:
  - SPLASH -> BOARD if start and frame_cnt >= SPLASH_FRAMES-1. Otherwise stay (start dropped).
  - BOARD -> OVER if game_over; else -> FLASH if hit.
  - FLASH -> OVER if game_over. Else -> BOARD when frame_cnt == FLASH_FRAMES-1. A hit during FLASH restarts the flash (frame_cnt=0).
  - OVER -> SPLASH if start.
- screen_sel is registered and updates on the same edge that H/V wrap to (0,0). It is never mid-frame.
- Reset mid-frame returns everything to reset values immediately. The first frame after release is complete, starting from (0,0).

Test Plan:
- Reset release, run 1 frame: frame_start period = 800*525*4 = 1,680,000 clks. hsync low for 384 clks per line. vsync low for 2 lines. video_on first high at H=144, V=35.
- SPLASH_FRAMES=2: start_req at frame 0 -> screen_sel stays 0. start_req in frame 1 -> screen_sel=1 at the next (0,0).
- In BOARD, hit_req mid-frame -> screen_sel=2 at the next boundary. Stays 2 for exactly FLASH_FRAMES=3 frames, then returns to 1.
- In FLASH, game_over_req and hit_req in the same cycle -> screen_sel=3 at the boundary. Pending hit is discarded; no flash after.
- Request pulse on the exact boundary cycle -> honoured at that boundary, not the next. start_req in BOARD -> ignored and pending cleared.
- Assert reset at H=400, V=200 -> all outputs return to reset values within the same cycle. screen_sel=0, counters restart from 0.
